// File: rtl/noc_flit_input_buffer.sv
// noc_flit_input_buffer: router input-port FWFT flit buffer.
// Stores valid flits from the network interface, presents the decoded head
// flit downstream with a valid/ready handshake, returns one credit per pop,
// and keeps sticky overflow/malformed flags.
// Optional macro NOC_IBUF_STATS_EN adds 16-bit push/drop statistics counters.
module noc_flit_input_buffer #(
  parameter int unsigned DEPTH = 4,
  localparam int unsigned CW = $clog2(DEPTH) + 1
) (
  input  logic          Clk,
  input  logic          Rst_n,
  input  logic [68:0]   i_flit,
  input  logic          i_flit_valid,
  input  logic          i_ready,
  input  logic          i_err_clr,
  output logic [63:0]   o_data,
  output logic [1:0]    o_dest,
  output logic          o_vc,
  output logic          o_tail,
  output logic          o_valid,
  output logic          o_credit,
  output logic [CW-1:0] o_count,
  output logic          o_full,
  output logic          o_overflow,
  output logic          o_malformed
`ifdef NOC_IBUF_STATS_EN
  ,
  output logic [15:0]   o_push_cnt,
  output logic [15:0]   o_drop_cnt
`endif
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [67:0]   mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          credit_q, credit_d;
  logic          overflow_q, overflow_d;
  logic          malformed_q, malformed_d;
  logic          push, pop, ovf_evt, mal_evt;
  logic [67:0]   head;
`ifdef NOC_IBUF_STATS_EN
  logic [15:0]   push_cnt_q, push_cnt_d;
  logic [15:0]   drop_cnt_q, drop_cnt_d;
`endif

  // Handshake events, all judged on pre-edge state (no pass-through when full)
  always_comb begin
    push    = i_flit_valid && i_flit[68] && !o_full;
    pop     = o_valid && i_ready;
    ovf_evt = i_flit_valid && i_flit[68] && o_full;
    mal_evt = i_flit_valid && !i_flit[68];
  end

  // Next-state for pointers, occupancy, credit and sticky flags
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    credit_d    = pop;
    overflow_d  = ovf_evt ? 1'b1 : (i_err_clr ? 1'b0 : overflow_q);
    malformed_d = mal_evt ? 1'b1 : (i_err_clr ? 1'b0 : malformed_q);
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

`ifdef NOC_IBUF_STATS_EN
  // Statistics: clear first, then increment, so a coinciding event yields 1
  always_comb begin
    push_cnt_d = i_err_clr ? '0 : push_cnt_q;
    drop_cnt_d = i_err_clr ? '0 : drop_cnt_q;
    if (push)              push_cnt_d = push_cnt_d + 16'd1;
    if (ovf_evt | mal_evt) drop_cnt_d = drop_cnt_d + 16'd1;
  end
`endif

  // Control state register with synchronous active-low reset
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      credit_q    <= 1'b0;
      overflow_q  <= 1'b0;
      malformed_q <= 1'b0;
`ifdef NOC_IBUF_STATS_EN
      push_cnt_q  <= '0;
      drop_cnt_q  <= '0;
`endif
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      credit_q    <= credit_d;
      overflow_q  <= overflow_d;
      malformed_q <= malformed_d;
`ifdef NOC_IBUF_STATS_EN
      push_cnt_q  <= push_cnt_d;
      drop_cnt_q  <= drop_cnt_d;
`endif
    end
  end

  // Flit storage, deliberately not reset; the valid bit is implied and not stored
  always_ff @(posedge Clk) begin
    if (push) mem_q[wr_ptr_q] <= i_flit[67:0];
  end

  assign head        = mem_q[rd_ptr_q];
  assign o_data      = head[63:0];
  assign o_vc        = head[64];
  assign o_dest      = head[66:65];
  assign o_tail      = head[67];
  assign o_count     = count_q;
  assign o_valid     = (count_q != '0);
  assign o_full      = (count_q == CW'(DEPTH));
  assign o_credit    = credit_q;
  assign o_overflow  = overflow_q;
  assign o_malformed = malformed_q;
`ifdef NOC_IBUF_STATS_EN
  assign o_push_cnt  = push_cnt_q;
  assign o_drop_cnt  = drop_cnt_q;
`endif

endmodule

// File: tb/tb_noc_flit_input_buffer.sv
// Testbench for noc_flit_input_buffer: directed stimulus, a queue-based
// reference model compared every cycle, and hand-computed literal checks.
// Honours NOC_IBUF_STATS_EN when defined.
module tb_noc_flit_input_buffer;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic          Clk = 1'b0;
  logic          Rst_n = 1'b0;
  logic [68:0]   i_flit = '0;
  logic          i_flit_valid = 1'b0;
  logic          i_ready = 1'b0;
  logic          i_err_clr = 1'b0;
  logic [63:0]   o_data;
  logic [1:0]    o_dest;
  logic          o_vc, o_tail, o_valid, o_credit, o_full, o_overflow, o_malformed;
  logic [CW-1:0] o_count;
`ifdef NOC_IBUF_STATS_EN
  logic [15:0]   o_push_cnt, o_drop_cnt;
`endif

  int errors = 0;
  int checks = 0;

  noc_flit_input_buffer #(.DEPTH(DEPTH)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .i_flit(i_flit), .i_flit_valid(i_flit_valid),
    .i_ready(i_ready), .i_err_clr(i_err_clr), .o_data(o_data), .o_dest(o_dest),
    .o_vc(o_vc), .o_tail(o_tail), .o_valid(o_valid), .o_credit(o_credit),
    .o_count(o_count), .o_full(o_full), .o_overflow(o_overflow),
    .o_malformed(o_malformed)
`ifdef NOC_IBUF_STATS_EN
    , .o_push_cnt(o_push_cnt), .o_drop_cnt(o_drop_cnt)
`endif
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a plain queue of stored flits plus flag/counter state
  logic [67:0] m_q[$];
  bit          m_init = 0;
  bit          m_credit, m_ovf, m_mal;
  logic [15:0] m_push_cnt, m_drop_cnt;

  always @(posedge Clk) begin
    bit pu, po, oe, me;
    if (!Rst_n) begin
      m_q.delete();
      m_credit = 0; m_ovf = 0; m_mal = 0;
      m_push_cnt = '0; m_drop_cnt = '0;
      m_init = 1;
    end else if (m_init) begin
      po = (m_q.size() != 0) && i_ready;
      pu = i_flit_valid && i_flit[68] && (m_q.size() < DEPTH);
      oe = i_flit_valid && i_flit[68] && (m_q.size() == DEPTH);
      me = i_flit_valid && !i_flit[68];
      m_credit = po;
      if (oe) m_ovf = 1; else if (i_err_clr) m_ovf = 0;
      if (me) m_mal = 1; else if (i_err_clr) m_mal = 0;
      if (i_err_clr) begin m_push_cnt = '0; m_drop_cnt = '0; end
      if (pu) m_push_cnt = m_push_cnt + 16'd1;
      if (oe || me) m_drop_cnt = m_drop_cnt + 16'd1;
      if (po) void'(m_q.pop_front());
      if (pu) m_q.push_back(i_flit[67:0]);
    end
  end

  // Every-cycle comparison against the model, away from the active edge
  always @(negedge Clk) begin
    if (m_init) begin
      chk("m_count", 64'(o_count), 64'(m_q.size()));
      chk("m_valid", 64'(o_valid), 64'(m_q.size() != 0));
      chk("m_full", 64'(o_full), 64'(m_q.size() == DEPTH));
      chk("m_credit", 64'(o_credit), 64'(m_credit));
      chk("m_overflow", 64'(o_overflow), 64'(m_ovf));
      chk("m_malformed", 64'(o_malformed), 64'(m_mal));
      if (m_q.size() != 0) begin
        chk("m_data", o_data, m_q[0][63:0]);
        chk("m_hdr", 64'({o_tail, o_dest, o_vc}), 64'({m_q[0][67], m_q[0][66:65], m_q[0][64]}));
      end
`ifdef NOC_IBUF_STATS_EN
      chk("m_push_cnt", 64'(o_push_cnt), 64'(m_push_cnt));
      chk("m_drop_cnt", 64'(o_drop_cnt), 64'(m_drop_cnt));
`endif
    end
  end

  function automatic logic [68:0] mk(input logic tail, input logic [1:0] dest,
                                     input logic vc, input logic [63:0] d);
    return {1'b1, tail, dest, vc, d};
  endfunction

  // Drive one cycle of inputs, then settle #1 after the edge
  task automatic step(input logic v, input logic [68:0] f, input logic r, input logic c);
    i_flit_valid = v; i_flit = f; i_ready = r; i_err_clr = c;
    @(posedge Clk);
    #1;
  endtask

  localparam logic [68:0] BAD = {1'b0, 68'h5_0000_0000_0000_1234};

  initial begin
    // Reset state
    Rst_n = 1'b0;
    step(0, '0, 0, 0);
    step(0, '0, 1, 0);
    chk("rst_count", 64'(o_count), 64'd0);
    chk("rst_valid", 64'(o_valid), 64'd0);
    chk("rst_full", 64'(o_full), 64'd0);
    chk("rst_credit", 64'(o_credit), 64'd0);
    chk("rst_flags", 64'({o_overflow, o_malformed}), 64'd0);
    Rst_n = 1'b1;

    // Single flit
    step(1, 69'h1D_DEADBEEF_CAFEF00D, 0, 0);
    chk("sf_valid", 64'(o_valid), 64'd1);
    chk("sf_data", o_data, 64'hDEADBEEFCAFEF00D);
    chk("sf_dest", 64'(o_dest), 64'd2);
    chk("sf_vc", 64'(o_vc), 64'd1);
    chk("sf_tail", 64'(o_tail), 64'd1);
    chk("sf_count", 64'(o_count), 64'd1);
    step(0, '0, 1, 0);
    chk("sf_pop_valid", 64'(o_valid), 64'd0);
    chk("sf_credit", 64'(o_credit), 64'd1);
    step(0, '0, 1, 0);
    chk("sf_credit_end", 64'(o_credit), 64'd0);

    // Fill and overflow
    for (int i = 1; i <= 5; i++) begin
      step(1, mk(1'(i & 1), 2'(i), 1'(i >> 1), 64'(i)), 0, 0);
      if (i == 4) chk("fill_full", 64'(o_full), 64'd1);
    end
    chk("fill_ovf", 64'(o_overflow), 64'd1);
    chk("fill_count", 64'(o_count), 64'd4);
    for (int i = 1; i <= 4; i++) begin
      chk("drain_data", o_data, 64'(i));
      step(0, '0, 1, 0);
      chk("drain_credit", 64'(o_credit), 64'd1);
    end
    chk("drain_empty", 64'(o_valid), 64'd0);
    step(0, '0, 0, 1);
    chk("ovf_clr", 64'(o_overflow), 64'd0);

    // Simultaneous push/pop across pointer wrap
    step(1, mk(0, 2'd1, 0, 64'd10), 0, 0);
    step(1, mk(0, 2'd2, 1, 64'd11), 0, 0);
    for (int k = 0; k < 6; k++) begin
      chk("pp_head", o_data, 64'(10 + k));
      step(1, mk(1'(k & 1), 2'(k), 1'(k >> 1), 64'(12 + k)), 1, 0);
      chk("pp_count", 64'(o_count), 64'd2);
    end
    step(1, mk(0, 2'd0, 0, 64'd18), 0, 0);
    step(1, mk(0, 2'd3, 0, 64'd19), 0, 0);
    chk("pp_full", 64'(o_full), 64'd1);
    step(1, mk(1, 2'd3, 1, 64'd20), 1, 0);
    chk("pp_full_count", 64'(o_count), 64'd3);
    chk("pp_full_ovf", 64'(o_overflow), 64'd1);
    chk("pp_full_head", o_data, 64'd17);
    step(0, '0, 0, 1);
    for (int k = 0; k < 3; k++) step(0, '0, 1, 0);

    // Malformed flit, including set winning over clear
    step(1, mk(0, 2'd1, 1, 64'd30), 0, 0);
    step(1, BAD, 0, 0);
    chk("mal_count", 64'(o_count), 64'd1);
    chk("mal_flag", 64'(o_malformed), 64'd1);
    step(1, BAD, 0, 1);
    chk("mal_set_wins", 64'(o_malformed), 64'd1);
    step(0, '0, 0, 1);
    chk("mal_clr", 64'(o_malformed), 64'd0);
    step(0, '0, 1, 0);

    // Reset mid-operation
    for (int k = 0; k < 3; k++) step(1, mk(0, 2'(k), 0, 64'(41 + k)), 0, 0);
    step(1, BAD, 0, 0);
    chk("rm_count_pre", 64'(o_count), 64'd3);
    Rst_n = 1'b0;
    step(0, '0, 1, 0);
    chk("rm_count", 64'(o_count), 64'd0);
    chk("rm_valid", 64'(o_valid), 64'd0);
    chk("rm_credit", 64'(o_credit), 64'd0);
    chk("rm_flags", 64'({o_overflow, o_malformed}), 64'd0);
    Rst_n = 1'b1;
    step(1, mk(1, 2'd2, 0, 64'd44), 0, 0);
    chk("rm_push_valid", 64'(o_valid), 64'd1);
    chk("rm_push_data", o_data, 64'd44);
    chk("rm_no_credit", 64'(o_credit), 64'd0);
    step(0, '0, 1, 0);

`ifdef NOC_IBUF_STATS_EN
    // Statistics counters
    step(0, '0, 0, 1);
    chk("st_clr_push", 64'(o_push_cnt), 64'd0);
    chk("st_clr_drop", 64'(o_drop_cnt), 64'd0);
    for (int k = 0; k < 3; k++) step(1, mk(0, 2'(k), 0, 64'(50 + k)), 0, 0);
    step(1, BAD, 0, 0);
    step(1, BAD, 0, 0);
    chk("st_push", 64'(o_push_cnt), 64'd3);
    chk("st_drop", 64'(o_drop_cnt), 64'd2);
    step(0, '0, 0, 1);
    chk("st_push_zero", 64'(o_push_cnt), 64'd0);
    chk("st_drop_zero", 64'(o_drop_cnt), 64'd0);
    step(1, mk(0, 2'd0, 0, 64'd60), 0, 1);
    chk("st_clr_inc", 64'(o_push_cnt), 64'd1);
    for (int k = 0; k < 4; k++) step(0, '0, 1, 0);
`endif

    step(0, '0, 0, 0);
    step(0, '0, 0, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
